// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared widths and output-format bit positions for the NPU
//                host-side interfaces.
//  Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam int NPU_DATA_W   = 16;  // one neuron result
    localparam int NPU_HOST_W   = 32;  // one host word

    // Output-format register bit positions
    localparam int FMT_PACK_BIT = 0;   // two results per host word
    localparam int FMT_SEXT_BIT = 1;   // sign-extend in unpacked mode

endpackage : npu_pkg
`default_nettype wire

// File: rtl/npu_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : npu_sync_fifo
//  Description : Synchronous FIFO, registered read data (no fall-through).
//                A push while full is dropped and flagged on drop_o; full is
//                judged on the pre-read occupancy, so a simultaneous pop does
//                not make room for that push.
//  Ports       : clk_i/rst_i     clock, async active-high reset
//                push_i/push_data_i  write request and word
//                pop_i           read request (ignored while empty)
//                pop_data_o      registered read word, holds between pops
//                empty_o/full_o/count_o  occupancy status
//                drop_o          this cycle's push is being discarded
//  Revision    : 1.0 - initial release
// ============================================================================
module npu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      count_o,
    output logic             drop_o
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o     = (count_q == C_DEPTH);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = rdata_q;
    assign w_do_push  = push_i && !full_o;
    assign w_do_pop   = pop_i && !empty_o;
    assign drop_o     = push_i && full_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (w_do_push) begin
            wptr_d = wptr_q + 1'b1;  // wraps modulo DEPTH
        end
        if (w_do_pop) begin
            rptr_d  = rptr_q + 1'b1;
            rdata_d = mem_q[rptr_q];
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage needs no reset: occupancy is governed entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule : npu_sync_fifo
`default_nettype wire

// File: rtl/npu_output_interface.sv
`default_nettype none
// ============================================================================
//  Module      : npu_output_interface
//  Description : Formats 16-bit NPU results into 32-bit host words (packed or
//                unpacked, optional sign extension), buffers them in a FIFO
//                and presents them to the host via read-enable / empty.
//  Ports       : CLK, RST                          clock, async reset
//                npu_output_interface_conf_data_en/_conf_data  format load
//                npu_output_fifo_write_en/_last, npu_output_interface_data_in
//                                                  result write strobe
//                npu_output_fifo_read_en           host pop
//                npu_output_data                   registered host word
//                npu_output_fifo_empty/_full/_count  FIFO status
//                npu_output_fifo_overflow          sticky dropped-push flag
//  Revision    : 1.0 - initial release
// ============================================================================
module npu_output_interface
    import npu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              npu_output_interface_conf_data_en,
    input  logic [15:0]       npu_output_interface_conf_data,
    input  logic              npu_output_fifo_write_en,
    input  logic              npu_output_fifo_last,
    input  logic [DATA_W-1:0] npu_output_interface_data_in,
    input  logic              npu_output_fifo_read_en,
    output logic [31:0]       npu_output_data,
    output logic              npu_output_fifo_empty,
    output logic              npu_output_fifo_full,
    output logic              npu_output_fifo_overflow,
    output logic [AW:0]       npu_output_fifo_count
);

    logic [1:0]            fmt_q, fmt_d;
    logic                  pending_q, pending_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic                  overflow_q, overflow_d;
    logic                  w_push;
    logic [NPU_HOST_W-1:0] w_push_word;
    logic                  w_drop;
    logic                  w_ext_bit;
    logic                  unused_conf;

    // Reserved format bits are accepted but have no effect.
    assign unused_conf = ^npu_output_interface_conf_data[15:2];

    assign w_ext_bit = fmt_q[FMT_SEXT_BIT] & npu_output_interface_data_in[DATA_W-1];

    always_comb begin
        fmt_d       = fmt_q;
        pending_d   = pending_q;
        hold_d      = hold_q;
        w_push      = 1'b0;
        w_push_word = '0;

        // The write is always formatted with the format in force this cycle.
        if (npu_output_fifo_write_en) begin
            if (fmt_q[FMT_PACK_BIT]) begin
                if (pending_q) begin
                    // Second half completes the word; last is irrelevant here.
                    w_push      = 1'b1;
                    w_push_word = {npu_output_interface_data_in, hold_q};
                    pending_d   = 1'b0;
                end else if (npu_output_fifo_last) begin
                    // Odd final result goes out alone, upper half zero.
                    w_push      = 1'b1;
                    w_push_word = {{(NPU_HOST_W-DATA_W){1'b0}}, npu_output_interface_data_in};
                end else begin
                    hold_d    = npu_output_interface_data_in;
                    pending_d = 1'b1;
                end
            end else begin
                w_push      = 1'b1;
                w_push_word = {{(NPU_HOST_W-DATA_W){w_ext_bit}}, npu_output_interface_data_in};
            end
        end

        // A format change discards any held half-word, overriding the packer.
        if (npu_output_interface_conf_data_en) begin
            fmt_d     = npu_output_interface_conf_data[1:0];
            pending_d = 1'b0;
        end
    end

    assign overflow_d = overflow_q | w_drop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fmt_q      <= '0;
            pending_q  <= 1'b0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            fmt_q      <= fmt_d;
            pending_q  <= pending_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    assign npu_output_fifo_overflow = overflow_q;

    npu_sync_fifo #(
        .WIDTH (NPU_HOST_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (w_push),
        .push_data_i (w_push_word),
        .pop_i       (npu_output_fifo_read_en),
        .pop_data_o  (npu_output_data),
        .empty_o     (npu_output_fifo_empty),
        .full_o      (npu_output_fifo_full),
        .count_o     (npu_output_fifo_count),
        .drop_o      (w_drop)
    );

endmodule : npu_output_interface
`default_nettype wire
